// File: rtl/dm_cache_pkg.sv
// Shared types and helpers for the direct-mapped write-through cache controller.
package dm_cache_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_WRITE = 2'd2
   } state_e;

   localparam int unsigned BLOCK_WORDS = 32'd4;
   localparam int unsigned OFFSET_W    = 32'd2;
   // Helpers take blocks widened to this word size, so WORD_W must not exceed it.
   localparam int unsigned MAX_WORD_W  = 32'd64;
   localparam int unsigned MAX_BLK_W   = BLOCK_WORDS * MAX_WORD_W;

   // Word k of a block whose offset 0 sits in the MSBs; w is the real word width.
   function automatic logic [MAX_WORD_W-1:0] block_word(
      input logic [MAX_BLK_W-1:0] blk,
      input logic [OFFSET_W-1:0]  k,
      input int unsigned          w
   );
      logic [MAX_BLK_W-1:0]  shifted;
      logic [MAX_WORD_W-1:0] mask;
      shifted = blk >> ((BLOCK_WORDS - 32'd1 - 32'(k)) * w);
      mask    = ~({MAX_WORD_W{1'b1}} << w);
      return shifted[MAX_WORD_W-1:0] & mask;
   endfunction

endpackage

// File: rtl/dm_cache_if.sv
// CPU-side and memory-side bus of dm_cache_ctrl; hit/miss counters exist only with DM_CACHE_STATS_EN.
interface dm_cache_if #(
   parameter int WORD_W = 32,
   parameter int ADDR_W = 32
);
   logic                                        cpu_req;
   logic                                        cpu_we;
   logic [ADDR_W-1:0]                           cpu_addr;
   logic [WORD_W-1:0]                           cpu_wdata;
   logic [WORD_W-1:0]                           cpu_rdata;
   logic                                        cpu_ready;
   logic [ADDR_W-1:0]                           mem_addr;
   logic [WORD_W-1:0]                           mem_wdata;
   logic                                        mem_read;
   logic                                        mem_write;
   logic [dm_cache_pkg::BLOCK_WORDS*WORD_W-1:0] mem_rdata;

`ifdef DM_CACHE_STATS_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      input  cpu_rdata, cpu_ready, mem_addr, mem_wdata, mem_read, mem_write,
      input  hit_cnt, miss_cnt
   );
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      output cpu_rdata, cpu_ready, mem_addr, mem_wdata, mem_read, mem_write,
      output hit_cnt, miss_cnt
   );
`else
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      input  cpu_rdata, cpu_ready, mem_addr, mem_wdata, mem_read, mem_write
   );
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      output cpu_rdata, cpu_ready, mem_addr, mem_wdata, mem_read, mem_write
   );
`endif
endinterface

// File: rtl/dm_cache_array.sv
// Valid/tag/data storage with combinational lookup, whole-line fill and single-word update.
module dm_cache_array
   import dm_cache_pkg::*;
#(
   parameter int  WORD_W   = 32,
   parameter int  ADDR_W   = 32,
   parameter int  NUM_SETS = 1024,
   localparam int IDX_W    = $clog2(NUM_SETS),
   localparam int TAG_W    = ADDR_W - IDX_W - int'(OFFSET_W),
   localparam int BLK_W    = int'(BLOCK_WORDS) * WORD_W
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [IDX_W-1:0]    i_idx,
   input  logic [TAG_W-1:0]    i_tag,
   input  logic [OFFSET_W-1:0] i_off,
   input  logic                i_fill_en,
   input  logic [BLK_W-1:0]    i_fill_data,
   input  logic                i_upd_en,
   input  logic [WORD_W-1:0]   i_upd_data,
   output logic                o_hit,
   output logic [WORD_W-1:0]   o_rdata
);

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [BLK_W-1:0] data;
   } line_t;

   line_t r_lines [NUM_SETS];
   line_t w_line;

   assign w_line  = r_lines[i_idx];
   assign o_hit   = w_line.valid && (w_line.tag == i_tag);
   assign o_rdata = WORD_W'(block_word(MAX_BLK_W'(w_line.data), i_off, WORD_W));

   // Line storage: reset clears only the valid bits; fill wins over a word update.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_SETS; i++) begin
            r_lines[i].valid <= 1'b0;
         end
      end else if (i_fill_en) begin
         r_lines[i_idx] <= '{valid: 1'b1, tag: i_tag, data: i_fill_data};
      end else if (i_upd_en) begin
         r_lines[i_idx].data[(int'(BLOCK_WORDS) - 1 - int'(i_off)) * WORD_W +: WORD_W] <= i_upd_data;
      end
   end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller (MEM stage <-> block memory).
// Optional hit/miss statistics counters are enabled by defining DM_CACHE_STATS_EN.
module dm_cache_ctrl
   import dm_cache_pkg::*;
#(
   parameter int WORD_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int NUM_SETS    = 1024,
   parameter int MEM_LATENCY = 4
)(
   input  logic     clk,
   input  logic     rst,
   dm_cache_if.slave bus
);

   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int TAG_W = ADDR_W - IDX_W - int'(OFFSET_W);
   localparam int CNT_W = $clog2(MEM_LATENCY + 1);

   state_e              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic                w_last;
   logic [OFFSET_W-1:0] w_off;
   logic [IDX_W-1:0]    w_idx;
   logic [TAG_W-1:0]    w_tag;
   logic                w_hit;
   logic [WORD_W-1:0]   w_arr_rdata;
   logic [WORD_W-1:0]   w_fill_word;
   logic                w_fill_en, w_upd_en;
   logic                w_ready, w_mem_read, w_mem_write;
   logic [WORD_W-1:0]   w_rdata, w_mem_wdata;
   logic [ADDR_W-1:0]   w_mem_addr;

   assign w_off       = bus.cpu_addr[OFFSET_W-1:0];
   assign w_idx       = bus.cpu_addr[IDX_W+int'(OFFSET_W)-1:OFFSET_W];
   assign w_tag       = bus.cpu_addr[ADDR_W-1:IDX_W+int'(OFFSET_W)];
   assign w_last      = (r_cnt == CNT_W'(MEM_LATENCY - 1));
   assign w_fill_word = WORD_W'(block_word(MAX_BLK_W'(bus.mem_rdata), w_off, WORD_W));

   dm_cache_array #(
      .WORD_W   (WORD_W),
      .ADDR_W   (ADDR_W),
      .NUM_SETS (NUM_SETS)
   ) u_array (
      .clk         (clk),
      .rst         (rst),
      .i_idx       (w_idx),
      .i_tag       (w_tag),
      .i_off       (w_off),
      .i_fill_en   (w_fill_en),
      .i_fill_data (bus.mem_rdata),
      .i_upd_en    (w_upd_en),
      .i_upd_data  (bus.cpu_wdata),
      .o_hit       (w_hit),
      .o_rdata     (w_arr_rdata)
   );

   // State and memory-latency counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state and all bus outputs; everything is forced quiet while rst is high.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ready     = 1'b0;
      w_rdata     = '0;
      w_mem_addr  = '0;
      w_mem_wdata = '0;
      w_mem_read  = 1'b0;
      w_mem_write = 1'b0;
      w_fill_en   = 1'b0;
      w_upd_en    = 1'b0;
      if (rst) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.cpu_req && bus.cpu_we) begin
                  w_state_nxt = S_WRITE;
                  w_cnt_nxt   = '0;
               end else if (bus.cpu_req && w_hit) begin
                  w_ready = 1'b1;
                  w_rdata = w_arr_rdata;
               end else if (bus.cpu_req) begin
                  w_state_nxt = S_FILL;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
            S_FILL: begin
               w_mem_read = 1'b1;
               w_mem_addr = {bus.cpu_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
               if (w_last) begin
                  w_fill_en   = 1'b1;
                  w_ready     = 1'b1;
                  w_rdata     = w_fill_word;
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            S_WRITE: begin
               w_mem_write = 1'b1;
               w_mem_addr  = bus.cpu_addr;
               w_mem_wdata = bus.cpu_wdata;
               if (w_last) begin
                  w_ready     = 1'b1;
                  w_upd_en    = w_hit;
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign bus.cpu_ready = w_ready;
   assign bus.cpu_rdata = w_rdata;
   assign bus.mem_addr  = w_mem_addr;
   assign bus.mem_wdata = w_mem_wdata;
   assign bus.mem_read  = w_mem_read;
   assign bus.mem_write = w_mem_write;

`ifdef DM_CACHE_STATS_EN
   logic [31:0] r_hit_cnt, r_miss_cnt;
   logic        w_hit_evt, w_miss_evt;

   assign w_hit_evt  = !rst && (r_state == S_IDLE) && bus.cpu_req && !bus.cpu_we && w_hit;
   assign w_miss_evt = !rst && (r_state == S_IDLE) && bus.cpu_req && !bus.cpu_we && !w_hit;

   // Saturating read hit/miss counters; writes are not counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hit_cnt  <= 32'd0;
         r_miss_cnt <= 32'd0;
      end else begin
         if (w_hit_evt && (r_hit_cnt != 32'hFFFF_FFFF)) begin
            r_hit_cnt <= r_hit_cnt + 32'd1;
         end
         if (w_miss_evt && (r_miss_cnt != 32'hFFFF_FFFF)) begin
            r_miss_cnt <= r_miss_cnt + 32'd1;
         end
      end
   end

   assign bus.hit_cnt  = r_hit_cnt;
   assign bus.miss_cnt = r_miss_cnt;
`endif

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate cache controller sitting between the CPU pipeline's MEM stage and the block data memory.
- The block data memory returns a 4-word block per read and accepts single-word writes. This block is the initiator on that interface.
- Stalls the CPU on misses and writes; serves read hits in the same cycle.

Parameters:
- WORD_W, 32, data word width (matches WORD_LEN).
- ADDR_W, 32, word address width (matches ADDRESS_LEN); address indexes words, not bytes.
- NUM_SETS, 1024, number of cache lines; power of two, at least 2.
- MEM_LATENCY, 4, cycles each memory read or write is held; at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cpu_req  in  1  access request; held stable with address/data/we until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  WORD_W  write data
- cpu_rdata  out  WORD_W  read data, valid when cpu_ready && !cpu_we
- cpu_ready  out  1  access completes this cycle (single-cycle pulse per access)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  WORD_W  memory write data
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_rdata  in  4*WORD_W  block; offset 0 in the MSBs [4W-1 -: W], offset 3 in the LSBs

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - All valid bits cleared, state IDLE, cycle counter 0.
  - All outputs 0 during reset and in IDLE with no request.
- Address split: offset = addr[1:0]; index = addr[IDX_W+1:2] with IDX_W = log2(NUM_SETS); tag = remaining upper bits.
- States: IDLE, FILL, WRITE.
- IDLE, read request:
  - Hit (valid[index] and tag match): cpu_ready=1 and cpu_rdata = line word[offset], combinationally in the same cycle. Remain in IDLE.
  - Miss: go to FILL and load cnt=0. cpu_ready=0.
- IDLE, write request: go to WRITE and load cnt=0. cpu_ready=0.
- FILL:
  - mem_read=1; mem_addr = {cpu_addr[ADDR_W-1:2], 2'b00}.
  - cnt increments each cycle.
  - On the cycle cnt==MEM_LATENCY-1:
    - write all 4 words from mem_rdata into the line, set the tag, set valid;
    - cpu_ready=1 and cpu_rdata = the mem_rdata word at offset (forwarded);
    - next state IDLE.
  - Read-miss latency is MEM_LATENCY cycles from the request cycle.
- WRITE:
  - mem_write=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata, held for MEM_LATENCY cycles.
  - On the last cycle: cpu_ready=1; if hit, update line word[offset] (tag/valid unchanged); if miss, the line is untouched.
  - Next state IDLE.
- Back-to-back: a new request may be presented the cycle after cpu_ready. There is no dead cycle beyond the IDLE evaluation cycle.
- cpu_req deasserted mid-FILL/WRITE is a protocol violation. The controller still completes the transaction.
- Reset mid-FILL/WRITE:
  - abort immediately; no line update;
  - the memory may already have committed the write (acceptable, write-through).
- A write to a line whose fill is in progress cannot occur (single outstanding access).
- mem_read and mem_write are never asserted together.

Optional Feature:
- Macro: DM_CACHE_STATS_EN.
- With it defined:
  - adds outputs hit_cnt and miss_cnt, 32 bits each, reset to 0;
  - hit_cnt increments on each IDLE read hit;
  - miss_cnt increments on each IDLE-to-FILL transition;
  - both saturate at all-ones;
  - writes are not counted.
- Without it: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package dm_cache_pkg:
  - state enum (IDLE, FILL, WRITE);
  - BLOCK_WORDS=4, OFFSET_W=2;
  - a line_t struct (valid, tag, 4 words) parameterised via localparams derived in the module;
  - a function extracting word k from a 4W block (MSB-first).
- Sub-module dm_cache_array:
  - valid/tag/data storage;
  - combinational lookup (hit, rdata), plus a fill port and a single-word update port;
  - synchronous valid clear on rst.
- The FSM and counter stay in dm_cache_ctrl.

Test Plan:
- After reset, read addr 0x40 with memory block 0x40..0x43 = {A,B,C,D}, MEM_LATENCY=4 → mem_read high 4 cycles at mem_addr 0x40; cpu_ready on the 4th cycle with rdata A; next read 0x42 → cpu_ready same cycle, rdata C, mem_read stays 0.
- Write 0x41=0x1234 (line cached) → mem_write 4 cycles with addr 0x41, data 0x1234; then read 0x41 → hit, 0x1234 in 0 stall cycles.
- Write 0x81 on an uncached line → memory written; a following read 0x81 misses (mem_read asserted), proving no-write-allocate.
- Conflict: read 0x40, then 0x40+4*NUM_SETS (same index, different tag), then 0x40 → three misses; line data follows each fill.
- Assert rst on cycle 2 of a FILL → next cycle all outputs 0; re-read 0x40 → miss again (valid cleared).
- With DM_CACHE_STATS_EN: sequence of miss, hit, hit, write → hit_cnt=2, miss_cnt=1.
